// File: rtl/soc_addr_pkg.sv
// SoC data-side address map: region bases, confreg offsets
// and the region tag used by the data SRAM responder.
package soc_addr_pkg;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h1C00_0000;
  localparam logic [31:0] CONF_BASE_DEF = 32'h1FAF_0000;

  localparam logic [15:0] CONF_LED    = 16'h0000;
  localparam logic [15:0] CONF_SWITCH = 16'h0004;
  localparam logic [15:0] CONF_NUM    = 16'h0008;
  localparam logic [15:0] CONF_TIMER  = 16'h000C;
  localparam logic [15:0] CONF_STCNT  = 16'h0010;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_CONF,
    REG_NONE
  } region_e;

endpackage

// File: rtl/data_confreg.sv
// Confreg block: LED, NUM, TIMER, store counter, synchronised
// switches and the register read mux.
module data_confreg
  import soc_addr_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [13:0] offset,
  input  logic        wen,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [15:0] switch,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [31:0] num
);

  logic [31:0] timer;
  logic [31:0] stcnt;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic sel_led;
  logic sel_sw;
  logic sel_num;
  logic sel_timer;
  logic sel_stcnt;

  // offset is a word offset, so compare against byte offsets >> 2
  assign sel_led   = offset == CONF_LED[15:2];
  assign sel_sw    = offset == CONF_SWITCH[15:2];
  assign sel_num   = offset == CONF_NUM[15:2];
  assign sel_timer = offset == CONF_TIMER[15:2];
  assign sel_stcnt = offset == CONF_STCNT[15:2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led     <= '0;
      num     <= '0;
      timer   <= '0;
      stcnt   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      if (wen && sel_led) led <= wdata[15:0];
      if (wen && sel_num) num <= wdata;
      if (wen && sel_timer) timer <= wdata;
      else timer <= timer + 32'd1;
      // counts every store, whatever region it targets
      if (we) stcnt <= stcnt + 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_led:   rdata = {16'h0, led};
      sel_sw:    rdata = {16'h0, sw_sync};
      sel_num:   rdata = num;
      sel_timer: rdata = timer;
      sel_stcnt: rdata = stcnt;
      default:   rdata = '0;
    endcase
  end

endmodule

// File: rtl/data_sram_responder.sv
// Single-cycle data SRAM responder: word RAM plus confreg,
// combinational read, write on the rising edge.
module data_sram_responder
  import soc_addr_pkg::*;
#(
  parameter int          RAM_AW    = 12,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch,
  output logic [15:0] led,
  output logic [31:0] num
);

  region_e            region;
  logic [RAM_AW-1:0]  ram_idx;
  logic [31:0]        conf_rdata;
  logic               conf_wen;
  logic               unused_ok;

  logic [31:0] ram [2**RAM_AW];

  assign ram_idx   = data_sram_addr[RAM_AW+1:2];
  assign unused_ok = &{1'b0, data_sram_addr[1:0]};

  always_comb begin
    region = REG_NONE;
    if (data_sram_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2])
      region = REG_RAM;
    else if (data_sram_addr[31:16] == CONF_BASE[31:16])
      region = REG_CONF;
  end

  // RAM contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (data_sram_we && region == REG_RAM)
      ram[ram_idx] <= data_sram_wdata;
  end

  assign conf_wen = data_sram_we && (region == REG_CONF);

  data_confreg u_confreg (
    .clk    (clk),
    .resetn (resetn),
    .offset (data_sram_addr[15:2]),
    .wen    (conf_wen),
    .wdata  (data_sram_wdata),
    .we     (data_sram_we),
    .switch (switch),
    .rdata  (conf_rdata),
    .led    (led),
    .num    (num)
  );

  always_comb begin
    data_sram_rdata = '0;
    unique case (region)
      REG_RAM:  data_sram_rdata = ram[ram_idx];
      REG_CONF: data_sram_rdata = conf_rdata;
      default:  data_sram_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: expected read data
// is queued when a request is driven and checked at negedge.
module tb_data_sram_responder;

  localparam logic [31:0] RAM_A   = 32'h1C00_0010;
  localparam logic [31:0] RAM_B   = 32'h1C00_0014;
  localparam logic [31:0] RAM_C   = 32'h1C00_0020;
  localparam logic [31:0] LED_A   = 32'h1FAF_0000;
  localparam logic [31:0] SW_A    = 32'h1FAF_0004;
  localparam logic [31:0] NUM_A   = 32'h1FAF_0008;
  localparam logic [31:0] TIMER_A = 32'h1FAF_000C;
  localparam logic [31:0] STCNT_A = 32'h1FAF_0010;
  localparam logic [31:0] NONE_A  = 32'h8000_0000;
  localparam logic [31:0] NONE_B  = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        data_sram_we = 1'b0;
  logic [31:0] data_sram_addr = '0;
  logic [31:0] data_sram_wdata = '0;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch = '0;
  logic [15:0] led;
  logic [31:0] num;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch          (switch),
    .led             (led),
    .num             (num)
  );

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    data_sram_we    = we;
    data_sram_addr  = a;
    data_sram_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] t;
    drive(1'b0, TIMER_A, '0);
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (led !== 16'h0) begin
      n_err++;
      $display("FAIL reset_led got %h want 0", led);
    end
    n_cmp++;
    if (num !== 32'h0) begin
      n_err++;
      $display("FAIL reset_num got %h want 0", num);
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = i;
      exp_q.push_back(t);
      @(negedge clk);
      got = data_sram_rdata;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL timer_after_reset[%0d] got %h want %h", i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_ram();
    drive(1'b1, RAM_A, 32'h1111_1111);
    step();
    drive(1'b1, RAM_B, 32'h2222_2222);
    step();
    drive(1'b1, RAM_A, 32'hDEAD_BEEF);
    exp_q.push_back(32'h1111_1111);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ram_same_cycle got %h want %h", got, exp);
    end
    step();
    drive(1'b0, RAM_A, '0);
    exp_q.push_back(32'hDEAD_BEEF);
    drive(1'b0, RAM_A, '0);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ram_readback got %h want %h", got, exp);
    end
    step();
    drive(1'b0, RAM_B, '0);
    exp_q.push_back(32'h2222_2222);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL ram_neighbour got %h want %h", got, exp);
    end
    step();
  endtask

  task automatic test_conf();
    drive(1'b1, LED_A, 32'h0001_A5A5);
    exp_q.push_back(32'h0);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL led_same_cycle got %h want %h", got, exp);
    end
    step();
    drive(1'b1, NUM_A, 32'h1234_5678);
    @(negedge clk);
    n_cmp++;
    if (led !== 16'hA5A5) begin
      n_err++;
      $display("FAIL led_port got %h want a5a5", led);
    end
    step();
    drive(1'b0, LED_A, '0);
    exp_q.push_back(32'h0000_A5A5);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL led_readback got %h want %h", got, exp);
    end
    n_cmp++;
    if (num !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL num_port got %h want 12345678", num);
    end
    step();
    drive(1'b0, NUM_A, '0);
    exp_q.push_back(32'h1234_5678);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL num_readback got %h want %h", got, exp);
    end
    step();
  endtask

  task automatic test_timer_wrap();
    logic [31:0] seq [4];
    seq[0] = 32'hFFFF_FFFE;
    seq[1] = 32'hFFFF_FFFF;
    seq[2] = 32'h0000_0000;
    seq[3] = 32'h0000_0001;
    drive(1'b1, TIMER_A, 32'hFFFF_FFFE);
    step();
    drive(1'b0, TIMER_A, '0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(seq[i]);
      @(negedge clk);
      got = data_sram_rdata;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL timer_wrap[%0d] got %h want %h", i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_switch();
    logic [31:0] seq [5];
    logic        wr  [5];
    seq[0] = 32'h0;   wr[0] = 1'b0;
    seq[1] = 32'h0;   wr[1] = 1'b0;
    seq[2] = 32'hF0;  wr[2] = 1'b0;
    seq[3] = 32'hF0;  wr[3] = 1'b1;
    seq[4] = 32'hF0;  wr[4] = 1'b0;
    switch = 16'h00F0;
    for (int i = 0; i < 5; i++) begin
      drive(wr[i], SW_A, 32'h0000_FFFF);
      exp_q.push_back(seq[i]);
      @(negedge clk);
      got = data_sram_rdata;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL switch_sync[%0d] got %h want %h", i, got, exp);
      end
      step();
    end
  endtask

  task automatic test_stcnt();
    logic [31:0] sa [5];
    logic [31:0] sd [5];
    logic [31:0] ra [4];
    logic [31:0] rv [4];
    sa[0] = RAM_C;  sd[0] = 32'hCAFE_0001;
    sa[1] = LED_A;  sd[1] = 32'h0000_0003;
    sa[2] = NONE_A; sd[2] = 32'h5555_5555;
    sa[3] = NUM_A;  sd[3] = 32'h0000_0077;
    sa[4] = NONE_B; sd[4] = 32'h6666_6666;
    ra[0] = STCNT_A; rv[0] = 32'd5;
    ra[1] = NONE_A;  rv[1] = 32'h0;
    ra[2] = RAM_C;   rv[2] = 32'hCAFE_0001;
    ra[3] = RAM_A;   rv[3] = 32'hDEAD_BEEF;
    drive(1'b0, STCNT_A, '0);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, sa[i], sd[i]);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, ra[i], '0);
      exp_q.push_back(rv[i]);
      @(negedge clk);
      got = data_sram_rdata;
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stcnt_read[%0d] got %h want %h", i, got, exp);
      end
      step();
    end
    n_cmp++;
    if (led !== 16'h0003) begin
      n_err++;
      $display("FAIL stcnt_led got %h want 0003", led);
    end
    n_cmp++;
    if (num !== 32'h77) begin
      n_err++;
      $display("FAIL stcnt_num got %h want 00000077", num);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, STCNT_A, 32'h0000_FFFF);
    #2 resetn = 1'b0;
    #1;
    exp_q.push_back(32'h0);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL async_stcnt got %h want %h", got, exp);
    end
    n_cmp++;
    if (led !== 16'h0 || num !== 32'h0) begin
      n_err++;
      $display("FAIL async_led_num got %h/%h want 0/0", led, num);
    end
    drive(1'b1, SW_A, 32'h0000_FFFF);
    #1;
    exp_q.push_back(32'h0);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL async_switch got %h want %h", got, exp);
    end
    drive(1'b1, LED_A, 32'h0000_FFFF);
    step();
    step();
    n_cmp++;
    if (led !== 16'h0) begin
      n_err++;
      $display("FAIL reset_we_led got %h want 0", led);
    end
    drive(1'b0, STCNT_A, '0);
    resetn = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    got = data_sram_rdata;
    exp = exp_q.pop_front();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_we_stcnt got %h want %h", got, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_conf();
    test_timer_wrap();
    test_switch();
    test_stcnt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
